// File: rtl/pipe_msg_reg.sv
// Inter-stage pipeline register for the packed msg bus: stall/flush control, tnew ageing and
// an optional mult/div busy timer. Define PIPE_PERF_CNT_EN to add bubble/stall counters.
`ifndef MAX
`define MAX 75
`endif
`ifndef INSTR
`define INSTR 31:0
`endif
`ifndef OPCODE
`define OPCODE 31:26
`endif
`ifndef FUNCT
`define FUNCT 5:0
`endif
`ifndef PC
`define PC 63:32
`endif
`ifndef TNEW
`define TNEW 66:64
`endif
`ifndef grfWE
`define grfWE 67
`endif
`ifndef tarReg
`define tarReg 72:68
`endif
`ifndef BUSY
`define BUSY 73
`endif
`ifndef MD
`define MD 74
`endif

module pipe_msg_reg #(
  parameter int MSG_W    = `MAX,
  parameter int DEC_TNEW = 1,
  parameter int MD_STAGE = 0,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [MSG_W-1:0] msg_in,
  output logic [MSG_W-1:0] msg_out,
  output logic             valid_out,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]      bubble_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic             md_busy
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int TMR_W  = $clog2(MD_MAX + 1);

  // Saturating tnew ageing: a result already available stays at 0.
  function automatic logic [2:0] age_tnew(input logic [2:0] t);
    return (t != 3'd0) ? t - 3'd1 : t;
  endfunction

  function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'd0) && (fn[5:2] == 4'b0110);
  endfunction

  logic [MSG_W-1:0] msg_p0;
  logic             vld_p0;
  logic [MSG_W-1:0] load_msg;
  logic [MSG_W-1:0] bubble_msg;
  logic             busy_md;

  always_comb begin
    load_msg         = msg_in;
    load_msg[`TNEW]  = (DEC_TNEW != 0) ? age_tnew(msg_in[`TNEW]) : msg_in[`TNEW];
    if (msg_in[`tarReg] == '0) load_msg[`grfWE] = 1'b0;
    bubble_msg       = '0;
    bubble_msg[`PC]  = msg_in[`PC];
  end

  // Stage boundary: upstream msg -> registered msg
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (flush) begin
      msg_p0 <= bubble_msg;
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      msg_p0 <= load_msg;
      vld_p0 <= 1'b1;
    end
  end

  generate
    if (MD_STAGE != 0) begin : g_md
      logic [TMR_W-1:0] timer_p0;
      logic             start;
      assign start = ~flush & ~stall & is_md(msg_in[`OPCODE], msg_in[`FUNCT]);

      // The timer keeps counting through stalls and flushes; only reset clears it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          timer_p0 <= '0;
        end else if (start) begin
          timer_p0 <= msg_in[1] ? TMR_W'(DIV_CYC) : TMR_W'(MULT_CYC);
        end else if (timer_p0 != '0) begin
          timer_p0 <= timer_p0 - 1'b1;
        end
      end
      assign busy_md = (timer_p0 != '0);
    end else begin : g_nomd
      assign busy_md = 1'b0;
    end
  endgenerate

  always_comb begin
    msg_out        = msg_p0;
    msg_out[`BUSY] = (MD_STAGE != 0) ? busy_md : msg_p0[`BUSY];
  end

  assign valid_out = vld_p0;
  assign md_busy   = busy_md;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end else if (stall) begin
      stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_msg_reg.sv
// Directed bench for pipe_msg_reg configured as the E-stage register (MD_STAGE=1).
module tb_pipe_msg_reg;

  localparam int MSG_W = 75;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [MSG_W-1:0] msg_in = '0;
  logic [MSG_W-1:0] msg_out;
  logic             valid_out;
  logic             md_busy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      bubble_cnt;
  logic [31:0]      stall_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  pipe_msg_reg #(
    .MSG_W(MSG_W), .DEC_TNEW(1), .MD_STAGE(1), .MULT_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .msg_in(msg_in), .msg_out(msg_out), .valid_out(valid_out),
`ifdef PIPE_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                          input logic [2:0] tn, input logic [4:0] tr,
                                          input logic we);
    logic [MSG_W-1:0] m;
    m = '0;
    m[31:0]  = ins;
    m[63:32] = pc;
    m[66:64] = tn;
    m[67]    = we;
    m[72:68] = tr;
    return m;
  endfunction

  initial begin
    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_msg", msg_out, 0);
    chk("rst_vld", valid_out, 0);
    chk("rst_busy", md_busy, 0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_bcnt", bubble_cnt, 0);
    chk("rst_scnt", stall_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // plain load: tnew 2 -> 1
    msg_in = mk(32'h3000, 32'h24010005, 3'd2, 5'd1, 1'b1);
    step();
    chk("ld_pc", msg_out[63:32], 32'h3000);
    chk("ld_instr", msg_out[31:0], 32'h24010005);
    chk("ld_tnew", msg_out[66:64], 1);
    chk("ld_we", msg_out[67], 1);
    chk("ld_vld", valid_out, 1);

    // stall holds for three cycles while input changes
    stall  = 1'b1;
    msg_in = mk(32'h3004, 32'h24020007, 3'd3, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", msg_out[63:32], 32'h3000);
      chk("stall_tnew", msg_out[66:64], 1);
      chk("stall_vld", valid_out, 1);
    end

    // flush wins over stall: bubble keeps pc only
    flush  = 1'b1;
    msg_in = mk(32'h3008, 32'h24030009, 3'd2, 5'd3, 1'b1);
    step();
    chk("fl_msg", msg_out, {11'd0, 32'h3008, 32'h0});
    chk("fl_vld", valid_out, 0);

    // tarReg 0 kills grfWE; tnew 0 saturates
    flush  = 1'b0;
    stall  = 1'b0;
    msg_in = mk(32'h300c, 32'h24000001, 3'd0, 5'd0, 1'b1);
    step();
    chk("tr0_we", msg_out[67], 0);
    chk("tr0_tnew", msg_out[66:64], 0);
    chk("tr0_vld", valid_out, 1);

    // non-md R-type does not start the timer
    msg_in = mk(32'h3010, 32'h00220020, 3'd1, 5'd3, 1'b1);
    step();
    chk("add_busy", md_busy, 0);

    // mult: busy exactly 5 cycles
    msg_in = mk(32'h3014, 32'h00220018, 3'd1, 5'd0, 1'b0);
    step();
    msg_in = mk(32'h3018, 32'h0, 3'd0, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", md_busy, 1);
      chk("mult_bit", msg_out[73], 1);
      step();
    end
    chk("mult_done", md_busy, 0);
    chk("mult_bit0", msg_out[73], 0);

    // div: busy exactly 10 cycles, flush at cycle 3 does not cancel it
    msg_in = mk(32'h301c, 32'h0022001a, 3'd1, 5'd0, 1'b0);
    step();
    msg_in = mk(32'h3020, 32'h0, 3'd0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("div_busy", md_busy, 1);
      chk("div_bit", msg_out[73], 1);
      flush = (i == 2);
      step();
      if (i == 2) chk("div_fl_vld", valid_out, 0);
    end
    flush = 1'b0;
    chk("div_done", md_busy, 0);

    // flushed or stalled mult must not start the timer
    msg_in = mk(32'h3024, 32'h00220019, 3'd1, 5'd0, 1'b0);
    flush  = 1'b1;
    step();
    chk("flmult_busy", md_busy, 0);
    flush  = 1'b0;
    stall  = 1'b1;
    step();
    chk("stmult_busy", md_busy, 0);
    stall  = 1'b0;

    // reload: mult then div two cycles later restarts at 10
    msg_in = mk(32'h3028, 32'h00220019, 3'd1, 5'd0, 1'b0);
    step();
    msg_in = mk(32'h302c, 32'h0, 3'd0, 5'd0, 1'b0);
    step();
    step();
    msg_in = mk(32'h3030, 32'h0022001b, 3'd1, 5'd0, 1'b0);
    step();
    msg_in = mk(32'h3034, 32'h0, 3'd0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("reload_busy", md_busy, 1);
      step();
    end
    chk("reload_done", md_busy, 0);

    // reset in the middle of a div clears everything without a clock edge
    msg_in = mk(32'h3038, 32'h0022001a, 3'd2, 5'd4, 1'b1);
    step();
    msg_in = mk(32'h303c, 32'h24050001, 3'd2, 5'd5, 1'b1);
    step();
    step();
    step();
    chk("mid_busy_pre", md_busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_busy", md_busy, 0);
    chk("mid_vld", valid_out, 0);
    chk("mid_msg", msg_out, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_pc", msg_out[63:32], 32'h303c);
    chk("post_tnew", msg_out[66:64], 1);
    chk("post_vld", valid_out, 1);

`ifdef PIPE_PERF_CNT_EN
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    stall = 1'b1;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    chk("perf_bcnt", bubble_cnt, 3);
    chk("perf_scnt", stall_cnt, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_msg_reg.md
Name: pipe_msg_reg

Overview:
- Inter-stage pipeline register that produces the packed `msg` bus consumed by the field splitter of the next stage (D/E, E/M or M/W).
- Latches the upstream msg each cycle, with stall (hold) and flush (bubble insertion).
- Ages the tnew field on each advance.
- When instantiated as the E-stage register, runs the mult/div busy timer and drives the msg busy bit.

Parameters:
- MSG_W, `MAX: width of the packed msg bus. Field slices use the existing macro.v field macros (`instr, `pc, `tnew, `grfWE, `tarReg, `md, `busy, …).
- DEC_TNEW, 1: 1 = decrement tnew by one on load (saturating at 0); 0 = pass tnew unchanged.
- MD_STAGE, 0: 1 = this instance owns the mult/div busy timer.
- MULT_CYC, 5: busy cycles for mult/multu.
- DIV_CYC, 10: busy cycles for div/divu.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  hold current contents
- flush  in  1  replace contents with a bubble
- msg_in  in  MSG_W  upstream packed message
- msg_out  out  MSG_W  registered packed message to the downstream stage
- valid_out  out  1  msg_out holds a real instruction (not a bubble)
- md_busy  out  1  mult/div timer running; constant 0 when MD_STAGE=0

Behaviour:
- Reset (reset=0, asynchronous):
  - msg_out = all zeros: nop bubble, grfWE=0, tarReg=0, tnew=0, busy=0.
  - valid_out=0, timer=0, md_busy=0.
- Priority at each posedge: flush > stall > load.
- Flush:
  - msg_out = all zeros except the pc field, which is copied from msg_in[`pc]. This keeps the pc trace continuous.
  - valid_out=0.
- Stall: msg_out and valid_out hold their values. tnew is not aged.
- Load:
  - msg_out = msg_in, except tnew = (DEC_TNEW && tnew_in!=0) ? tnew_in-1 : tnew_in.
  - valid_out=1.
- Bubble markers: a bubble never carries grfWE=1. In any loaded msg with tarReg==0, force grfWE to 0.
- MD timer (MD_STAGE=1):
  - Start condition: the msg actually loaded (not flushed, not stalled) has instr[31:26]==0 and funct ∈ {0x18,0x19} (mult, multu) or {0x1a,0x1b} (div, divu).
  - On start, the timer loads MULT_CYC or DIV_CYC on the same edge.
  - Otherwise, if timer!=0, the timer decrements every cycle, regardless of stall or flush.
  - md_busy = (timer!=0), registered. It is asserted the first cycle after the md instruction is loaded.
  - msg_out[`busy] = md_busy, overriding the stored bit combinationally.
  - A flush arriving while the timer runs does not cancel it.
  - A new start while the timer is nonzero reloads it. This case cannot occur under correct hazard logic; the bench checks reload behaviour.
- Timer width: ceil(log2(max(MULT_CYC,DIV_CYC)+1)) bits.
- stall and flush in the same cycle: flush wins. The bubble is inserted and the held instruction is discarded.
- reset deasserted mid-operation: the first posedge after deassertion performs a normal load, flush or stall.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - Adds outputs `bubble_cnt` (32) and `stall_cnt` (32).
  - `bubble_cnt` increments on every flush edge; `stall_cnt` increments on every stall edge where flush=0.
  - Both wrap at 2^32 and clear on reset.
- PIPE_PERF_CNT_EN not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then load with stall=0, flush=0: msg_in pc=0x3000, instr=0x24010005, tnew=2, tarReg=1, grfWE=1 -> after one edge, msg_out pc=0x3000, tnew=1, grfWE=1, valid_out=1.
- Stall: stall=1 for 3 cycles while msg_in changes to pc=0x3004 -> msg_out stays pc=0x3000, tnew=1 throughout.
- Flush and stall together: flush=1, stall=1, msg_in pc=0x3008 -> msg_out instr=0, grfWE=0, tnew=0, pc=0x3008, valid_out=0.
- MD timer, MD_STAGE=1: load mult (instr=0x00220018) -> md_busy=1 for exactly 5 cycles, msg_out[`busy]=1 during them. Then load div (0x0022001a) -> md_busy=1 for 10 cycles, including while flush is pulsed at cycle 3.
- Reset mid-operation: assert reset at cycle 4 of a div -> md_busy, valid_out and msg_out go to 0 immediately, without waiting for a clock edge.
- With PIPE_PERF_CNT_EN: apply 2 flushes, then 3 stalls, then 1 flush+stall -> bubble_cnt=3, stall_cnt=3.
